char_motion_ctrl: RTL and testbench

Parametrised successor to the character position block. It steps the character on a slow internal tick from keypad directions and runs a ground/rise/fall jump FSM. Collisions are checked *before* each move by probing the external blocking RAM (predictive), so positions are never rolled back after a hit. It sits between the keypad decoder and the renderer/scroller, and drives the blocking-RAM read port directly.

---
 rtl/char_motion_ctrl_if.sv | 31 +++
 rtl/char_motion_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_char_motion_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/char_motion_ctrl_if.sv
// ------------------------------------------------------------------------
// char_motion_ctrl_if : keypad, blocking-RAM and position bus. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface char_motion_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 20
) ();
  logic [3:0]         mov;
  logic [ADDR_W-1:0]  blk_addr;
  logic               blk_in;
  logic [COORD_W-1:0] char_x;
  logic [COORD_W-1:0] char_y;
  logic               on_ground;
  logic               jumping;
  logic               busy;
  logic               move_done;

  modport master (
    input  mov, blk_in,
    output blk_addr, char_x, char_y, on_ground, jumping, busy, move_done
  );

  modport slave (
    output mov, blk_in,
    input  blk_addr, char_x, char_y, on_ground, jumping, busy, move_done
  );
endinterface

`default_nettype wire

// File: rtl/char_motion_ctrl.sv
// ------------------------------------------------------------------------
// char_motion_ctrl : tick-driven character motion with predictive collision probing. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module char_motion_ctrl #(
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 20,
  parameter int MAP_W    = 960,
  parameter int MAP_H    = 500,
  parameter int X_INIT   = 244,
  parameter int Y_INIT   = 350,
  parameter int TICK_DIV = 200000,
  parameter int JUMP_H   = 48,
  parameter int RAM_LAT  = 1
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  char_motion_if.master bus
);

  localparam int TC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WC_W   = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int JC_W   = $clog2(JUMP_H + 1);
  localparam int FULL_W = COORD_W + 32;

  localparam logic [TC_W-1:0]    C_TICK_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [WC_W-1:0]    C_WAIT_LAST = WC_W'(RAM_LAT - 1);
  localparam logic [JC_W-1:0]    C_JUMP_H    = JC_W'(JUMP_H);
  localparam logic [COORD_W-1:0] C_X_MAX     = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] C_Y_FLOOR   = COORD_W'(MAP_H);
  localparam logic [COORD_W-1:0] C_X_INIT    = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] C_Y_INIT    = COORD_W'(Y_INIT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PROBE_H = 3'd1;
  localparam logic [2:0] S_WAIT_H  = 3'd2;
  localparam logic [2:0] S_PROBE_V = 3'd3;
  localparam logic [2:0] S_WAIT_V  = 3'd4;
  localparam logic [2:0] S_COMMIT  = 3'd5;

  localparam logic [1:0] V_GROUND = 2'd0;
  localparam logic [1:0] V_RISE   = 2'd1;
  localparam logic [1:0] V_FALL   = 2'd2;

  logic [TC_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic               tick_q, tick_d;
  logic [2:0]         state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  // Latched keypad: [2]=up, [1]=left, [0]=right; down is not stored.
  logic [2:0]         mov_q, mov_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] xn_q, xn_d;
  logic [1:0]         vst_q, vst_d;
  logic [JC_W-1:0]    jcnt_q, jcnt_d;
  logic [ADDR_W-1:0]  blk_addr_q, blk_addr_d;
  logic               vprobe_q, vprobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_right, w_left, w_h_ok;
  logic [COORD_W-1:0] w_x_cand, w_x_next;
  logic               w_jump_start;
  logic [1:0]         w_vmode;
  logic [JC_W-1:0]    w_jbase, w_jnext;
  logic [COORD_W-1:0] w_y_up, w_y_dn, w_v_addr_y;
  logic               w_v_probe, w_v_clear;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] cx,
                                                 input logic [COORD_W-1:0] cy);
    logic [FULL_W-1:0] full;
    full = FULL_W'(cy) * FULL_W'(MAP_W) + FULL_W'(cx);
    return full[ADDR_W-1:0];
  endfunction

  always_comb begin
    w_right      = mov_q[0] & ~mov_q[1];
    w_left       = mov_q[1] & ~mov_q[0];
    w_h_ok       = (w_right && (x_q < C_X_MAX)) || (w_left && (x_q != '0));
    w_x_cand     = w_right ? (x_q + 1'b1) : (x_q - 1'b1);
    // Only valid in PROBE_V, where blk_in carries the horizontal probe result.
    w_x_next     = (w_h_ok && !bus.blk_in) ? w_x_cand : x_q;
    // A jump request from GROUND is evaluated as a RISE step on the same tick.
    w_jump_start = (vst_q == V_GROUND) && mov_q[2];
    w_vmode      = w_jump_start ? V_RISE : vst_q;
    w_jbase      = w_jump_start ? '0 : jcnt_q;
    w_jnext      = w_jbase + 1'b1;
    w_y_up       = y_q - 1'b1;
    w_y_dn       = y_q + 1'b1;
    w_v_probe    = (w_vmode == V_RISE) ? (y_q != '0) : (y_q < C_Y_FLOOR);
    w_v_addr_y   = (w_vmode == V_RISE) ? w_y_up : w_y_dn;
    w_v_clear    = vprobe_q && !bus.blk_in;
  end

  always_comb begin
    tick_cnt_d = (tick_cnt_q == C_TICK_LAST) ? '0 : (tick_cnt_q + 1'b1);
    tick_d     = (tick_cnt_q == C_TICK_LAST);
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mov_d      = mov_q;
    x_d        = x_q;
    y_d        = y_q;
    xn_d       = xn_q;
    vst_d      = vst_q;
    jcnt_d     = jcnt_q;
    blk_addr_d = blk_addr_q;
    vprobe_d   = vprobe_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          mov_d   = {bus.mov[3], bus.mov[1], bus.mov[0]};
          state_d = S_PROBE_H;
        end
      end
      S_PROBE_H: begin
        if (w_h_ok) begin
          blk_addr_d = pix_addr(w_x_cand, y_q);
        end
        wait_cnt_d = '0;
        state_d    = S_WAIT_H;
      end
      S_WAIT_H: begin
        if (wait_cnt_q == C_WAIT_LAST) begin
          state_d = S_PROBE_V;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_PROBE_V: begin
        xn_d     = w_x_next;
        vprobe_d = w_v_probe;
        if (w_v_probe) begin
          blk_addr_d = pix_addr(w_x_next, w_v_addr_y);
        end
        wait_cnt_d = '0;
        state_d    = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (wait_cnt_q == C_WAIT_LAST) begin
          state_d = S_COMMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        x_d     = xn_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (w_vmode)
          V_RISE: begin
            if (w_v_clear) begin
              y_d    = w_y_up;
              jcnt_d = w_jnext;
              vst_d  = (w_jnext == C_JUMP_H) ? V_FALL : V_RISE;
            end else begin
              jcnt_d = w_jbase;
              vst_d  = V_FALL;
            end
          end
          V_GROUND: begin
            if (w_v_clear) begin
              y_d   = w_y_dn;
              vst_d = V_FALL;
            end
          end
          default: begin
            if (w_v_clear) begin
              y_d = w_y_dn;
            end else begin
              vst_d = V_GROUND;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mov_q      <= '0;
      x_q        <= C_X_INIT;
      y_q        <= C_Y_INIT;
      xn_q       <= C_X_INIT;
      vst_q      <= V_FALL;
      jcnt_q     <= '0;
      blk_addr_q <= '0;
      vprobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mov_q      <= mov_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xn_q       <= xn_d;
      vst_q      <= vst_d;
      jcnt_q     <= jcnt_d;
      blk_addr_q <= blk_addr_d;
      vprobe_q   <= vprobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.blk_addr  = blk_addr_q;
  assign bus.char_x    = x_q;
  assign bus.char_y    = y_q;
  assign bus.on_ground = (vst_q == V_GROUND);
  assign bus.jumping   = (vst_q == V_RISE);
  assign bus.busy      = busy_q;
  assign bus.move_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_char_motion_ctrl.sv
// ------------------------------------------------------------------------
// tb_char_motion_ctrl : directed self-checking bench for char_motion_ctrl. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_char_motion_ctrl;

  localparam logic [19:0] NONE = 20'hFFFFF;

  logic sys_clk;
  logic rst_n;

  char_motion_if #(.COORD_W(10), .ADDR_W(20)) bus ();

  char_motion_ctrl #(
    .COORD_W(10), .ADDR_W(20), .MAP_W(960), .MAP_H(500), .X_INIT(244),
    .Y_INIT(350), .TICK_DIV(16), .JUMP_H(48), .RAM_LAT(1)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int          n_checks;
  int          n_errors;
  int          c;
  logic [19:0] solid_a;
  logic [19:0] watch_addr;
  logic [9:0]  bad_x;
  logic        seen_watch;
  logic        seen_bad;
  logic        addr_moved;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Registered-read blocking RAM: only solid_a is solid.
  always @(posedge sys_clk) bus.blk_in <= (bus.blk_addr == solid_a);

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    logic [19:0] a0;
    a0         = bus.blk_addr;
    cyc        = 0;
    seen_watch = 1'b0;
    seen_bad   = 1'b0;
    addr_moved = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (bus.blk_addr != a0)         addr_moved = 1'b1;
      if (bus.blk_addr == watch_addr) seen_watch = 1'b1;
      if (bus.char_x == bad_x)        seen_bad   = 1'b1;
      if (bus.move_done) break;
    end
    if (!bus.move_done) chk_eq("done_timeout", int'(bus.move_done), 1);
  endtask

  task automatic run_ticks(input int n);
    int cc;
    for (int i = 0; i < n; i++) wait_done(cc);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    solid_a    = NONE;
    watch_addr = NONE;
    bad_x      = 10'h3FF;
    bus.mov    = 4'b0000;
    rst_n      = 1'b0;
    repeat (3) @(negedge sys_clk);

    chk_eq("rst_x",      int'(bus.char_x), 244);
    chk_eq("rst_y",      int'(bus.char_y), 350);
    chk_eq("rst_busy",   int'(bus.busy), 0);
    chk_eq("rst_done",   int'(bus.move_done), 0);
    chk_eq("rst_ground", int'(bus.on_ground), 0);
    chk_eq("rst_jump",   int'(bus.jumping), 0);
    chk_eq("rst_addr",   int'(bus.blk_addr), 0);
    rst_n = 1'b1;

    // Fall from reset position to the floor.
    wait_done(c);
    chk_eq("first_latency", c, 22);
    chk_eq("fall1_y", int'(bus.char_y), 351);
    chk_eq("fall1_x", int'(bus.char_x), 244);
    chk_eq("fall1_ground", int'(bus.on_ground), 0);
    wait_done(c);
    chk_eq("tick_period", c, 16);
    chk_eq("fall2_y", int'(bus.char_y), 352);
    run_ticks(148);
    chk_eq("floor_y", int'(bus.char_y), 500);
    chk_eq("floor_ground_pre", int'(bus.on_ground), 0);
    wait_done(c);
    chk_eq("land_ground", int'(bus.on_ground), 1);
    chk_eq("land_y", int'(bus.char_y), 500);
    chk_eq("land_jump", int'(bus.jumping), 0);
    wait_done(c);
    chk_eq("stay_y", int'(bus.char_y), 500);
    chk_eq("stay_ground", int'(bus.on_ground), 1);

    // Walking right, both keys, then left.
    bus.mov = 4'b0001;
    run_ticks(5);
    chk_eq("walk_r_x", int'(bus.char_x), 249);
    chk_eq("walk_r_y", int'(bus.char_y), 500);
    bus.mov = 4'b0011;
    run_ticks(1);
    chk_eq("both_x", int'(bus.char_x), 249);
    bus.mov = 4'b0010;
    run_ticks(5);
    chk_eq("walk_l_x", int'(bus.char_x), 244);

    // Wall at (245,500).
    solid_a    = 20'd480245;
    watch_addr = 20'd480245;
    bad_x      = 10'd245;
    bus.mov    = 4'b0001;
    wait_done(c);
    chk_eq("wall_probe_addr", int'(seen_watch), 1);
    chk_eq("wall_never_245", int'(seen_bad), 0);
    chk_eq("wall_x", int'(bus.char_x), 244);
    bad_x      = 10'h3FF;
    watch_addr = NONE;
    solid_a    = NONE;

    // Full jump from (300,500) with up held for the first three rises.
    run_ticks(56);
    chk_eq("to300_x", int'(bus.char_x), 300);
    bus.mov = 4'b1000;
    wait_done(c);
    chk_eq("jump1_y", int'(bus.char_y), 499);
    chk_eq("jump1_rise", int'(bus.jumping), 1);
    chk_eq("jump1_ground", int'(bus.on_ground), 0);
    run_ticks(2);
    chk_eq("jump3_y", int'(bus.char_y), 497);
    bus.mov = 4'b0000;
    run_ticks(45);
    chk_eq("apex_y", int'(bus.char_y), 452);
    chk_eq("apex_rise", int'(bus.jumping), 0);
    chk_eq("apex_ground", int'(bus.on_ground), 0);
    run_ticks(48);
    chk_eq("down_y", int'(bus.char_y), 500);
    chk_eq("down_ground_pre", int'(bus.on_ground), 0);
    run_ticks(1);
    chk_eq("down_ground", int'(bus.on_ground), 1);

    // Ceiling at (300,480).
    solid_a = 20'd461100;
    bus.mov = 4'b1000;
    wait_done(c);
    bus.mov = 4'b0000;
    run_ticks(18);
    chk_eq("ceil_y", int'(bus.char_y), 481);
    chk_eq("ceil_rise", int'(bus.jumping), 1);
    run_ticks(1);
    chk_eq("ceil_hit_y", int'(bus.char_y), 481);
    chk_eq("ceil_hit_rise", int'(bus.jumping), 0);
    chk_eq("ceil_hit_ground", int'(bus.on_ground), 0);
    run_ticks(19);
    chk_eq("ceil_down_y", int'(bus.char_y), 500);
    run_ticks(1);
    chk_eq("ceil_land", int'(bus.on_ground), 1);
    solid_a = NONE;

    // Left and right map edges.
    bus.mov = 4'b0010;
    run_ticks(300);
    chk_eq("left_edge_x", int'(bus.char_x), 0);
    wait_done(c);
    chk_eq("left_edge_stay", int'(bus.char_x), 0);
    chk_eq("left_edge_noprobe", int'(addr_moved), 0);
    bus.mov = 4'b0001;
    run_ticks(959);
    chk_eq("right_edge_x", int'(bus.char_x), 959);
    wait_done(c);
    chk_eq("right_edge_stay", int'(bus.char_x), 959);
    chk_eq("right_edge_noprobe", int'(addr_moved), 0);

    // Reset during WAIT_V of a left step.
    bus.mov = 4'b0010;
    wait_done(c);
    chk_eq("edge_left_x", int'(bus.char_x), 958);
    repeat (14) @(negedge sys_clk);
    chk_eq("mid_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_eq("arst_x", int'(bus.char_x), 244);
    chk_eq("arst_y", int'(bus.char_y), 350);
    chk_eq("arst_busy", int'(bus.busy), 0);
    chk_eq("arst_ground", int'(bus.on_ground), 0);
    chk_eq("arst_jump", int'(bus.jumping), 0);
    chk_eq("arst_done", int'(bus.move_done), 0);
    bus.mov = 4'b0000;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_done(c);
    chk_eq("post_rst_latency", c, 22);
    chk_eq("post_rst_x", int'(bus.char_x), 244);
    chk_eq("post_rst_y", int'(bus.char_y), 351);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
